// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a word-only data memory port.
// Accepts one request at a time. Loads are formatted with sign or zero
// extension, and sub-word stores are done as read-modify-write.
// Each request produces exactly one response pulse.
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high. req_ready_o is high only while idle and out of
// reset. The response is a single-cycle resp_valid_o pulse with
// resp_rdata_o/resp_err_o valid alongside it. There is no backpressure on
// the response side.
module load_store_unit #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCESS  = 3'd1,
        S_CAPTURE = 3'd2,
        S_MERGE   = 3'd3,
        S_WRITE   = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t      state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;      // only the low half is ever merged
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        req_illegal_d;
    logic        req_misal_d;
    logic        req_err_d;
    logic        req_sw_d;
    logic [1:0]  req_off_d;
    logic [31:0] shifted_d;
    logic [31:0] load_data_d;
    logic [31:0] merge_data_d;

    // Decode the incoming request: legality, alignment and the effective byte offset
    always_comb begin
        if (req_we_i) begin
            req_illegal_d = req_funct3_i[2] | (req_funct3_i[1:0] == 2'b11);
        end else begin
            req_illegal_d = (req_funct3_i == 3'b011) | (req_funct3_i[2:1] == 2'b11);
        end
        req_off_d   = req_addr_i[1:0];
        req_misal_d = 1'b0;
        case (req_funct3_i[1:0])
            2'b01: begin
                req_misal_d = req_addr_i[0];
                if (!CHECK_ALIGN) req_off_d = {req_addr_i[1], 1'b0};
            end
            2'b10: begin
                req_misal_d = |req_addr_i[1:0];
                if (!CHECK_ALIGN) req_off_d = 2'b00;
            end
            default: ;
        endcase
        req_err_d = req_illegal_d | (CHECK_ALIGN & req_misal_d);
        req_sw_d  = req_we_i & (req_funct3_i == 3'b010);
    end

    // Format load data from the read word (little-endian lane select, then extend)
    always_comb begin
        shifted_d = mem_rdata_i >> {off_q, 3'b000};
        case (funct3_q[1:0])
            2'b00:   load_data_d = funct3_q[2] ? {24'd0, shifted_d[7:0]}
                                               : {{24{shifted_d[7]}}, shifted_d[7:0]};
            2'b01:   load_data_d = funct3_q[2] ? {16'd0, shifted_d[15:0]}
                                               : {{16{shifted_d[15]}}, shifted_d[15:0]};
            default: load_data_d = mem_rdata_i;
        endcase
    end

    // Splice the store byte/half into the word just read back
    always_comb begin
        merge_data_d = mem_rdata_i;
        if (funct3_q[1:0] == 2'b00) begin
            merge_data_d[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merge_data_d[{off_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            wdata_q      <= 16'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            resp_valid_q <= 1'b0;
            mem_we_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        we_q         <= req_we_i;
                        funct3_q     <= req_funct3_i;
                        off_q        <= req_off_d;
                        wdata_q      <= req_wdata_i[15:0];
                        mem_addr_q   <= {req_addr_i[31:2], 2'b00};
                        resp_rdata_q <= 32'd0;
                        resp_err_q   <= req_err_d;
                        if (req_err_d) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            // A full-word store goes straight out in ACCESS
                            if (req_sw_d) begin
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= req_wdata_i;
                            end
                            state_q <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!we_q) begin
                        state_q <= S_CAPTURE;
                    end else if (funct3_q == 3'b010) begin
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        state_q <= S_MERGE;
                    end
                end
                S_CAPTURE: begin
                    resp_rdata_q <= load_data_d;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_MERGE: begin
                    mem_wdata_q <= merge_data_d;
                    mem_we_q    <= 1'b1;
                    state_q     <= S_WRITE;
                end
                S_WRITE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = (state_q == S_IDLE) & ~rst_i;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (alignment checking on and off)
// share one request stream. Each instance has its own word memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_ready_w [2];
    logic        resp_valid_w[2];
    logic [31:0] resp_rdata_w[2];
    logic        resp_err_w  [2];
    logic        mem_we_w    [2];
    logic [31:0] mem_addr_w  [2];
    logic [31:0] mem_wdata_w [2];
    logic [31:0] mem_rdata_w [2];
    logic [2:0]  state_w     [2];

    logic [31:0] mem     [2][64];
    logic [31:0] refm    [2][64];
    logic [31:0] init_mem[64];
    logic        preload;

    int n_checks = 0;
    int n_fail   = 0;

    int          obs_lat   [2];
    int          obs_nresp [2];
    logic [31:0] obs_rdata [2];
    logic        obs_err   [2];
    int          obs_wcnt  [2];
    int          obs_wcyc  [2];
    logic [31:0] obs_wdata [2];
    logic [31:0] obs_waddr [2];
    logic        obs_badal [2];

    always #5 clk = ~clk;

    load_store_unit #(.CHECK_ALIGN(1'b1)) u_dut0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_w[0]),
        .req_we_i(req_we), .req_funct3_i(req_funct3),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid_w[0]), .resp_rdata_o(resp_rdata_w[0]),
        .resp_err_o(resp_err_w[0]),
        .mem_we_o(mem_we_w[0]), .mem_addr_o(mem_addr_w[0]),
        .mem_wdata_o(mem_wdata_w[0]), .mem_rdata_i(mem_rdata_w[0]),
        .state_o(state_w[0])
    );

    load_store_unit #(.CHECK_ALIGN(1'b0)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_w[1]),
        .req_we_i(req_we), .req_funct3_i(req_funct3),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid_w[1]), .resp_rdata_o(resp_rdata_w[1]),
        .resp_err_o(resp_err_w[1]),
        .mem_we_o(mem_we_w[1]), .mem_addr_o(mem_addr_w[1]),
        .mem_wdata_o(mem_wdata_w[1]), .mem_rdata_i(mem_rdata_w[1]),
        .state_o(state_w[1])
    );

    // Word memories: synchronous read, write on posedge
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (preload) begin
                for (int i = 0; i < 64; i++) mem[d][i] <= init_mem[i];
            end else if (mem_we_w[d]) begin
                mem[d][mem_addr_w[d][7:2]] <= mem_wdata_w[d];
            end
            mem_rdata_w[d] <= mem[d][mem_addr_w[d][7:2]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: byte-lane view of a word memory, straight from the access rules
    function automatic void model(input int d, input bit chk_al, input bit we,
                                  input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd,
                                  output logic [31:0] rd, output bit err,
                                  output int lat, output int nwe, output int wcyc,
                                  output logic [31:0] wword);
        int nbytes;
        int off;
        int idx;
        int a;
        bit legal;
        logic [31:0] w;
        logic [31:0] mask;
        nbytes = 1 << int'(f3[1:0]);
        legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        a      = int'(addr[1:0]);
        err    = !legal || (chk_al && (a % nbytes) != 0);
        rd = 32'd0; nwe = 0; wcyc = 0; wword = 32'd0; lat = 1;
        if (err) return;
        off = a - (a % nbytes);
        idx = int'(addr[7:2]);
        w   = refm[d][idx];
        if (!we) begin
            lat  = 3;
            mask = (nbytes == 4) ? 32'hffffffff : ((32'd1 << (8 * nbytes)) - 32'd1);
            rd   = (w >> (8 * off)) & mask;
            if (!f3[2] && nbytes < 4 && rd[8 * nbytes - 1]) rd = rd | ~mask;
        end else begin
            for (int i = 0; i < nbytes; i++) w[8 * (off + i) +: 8] = wd[8 * i +: 8];
            refm[d][idx] = w;
            nwe   = 1;
            wword = w;
            lat   = (nbytes == 4) ? 2 : 4;
            wcyc  = (nbytes == 4) ? 1 : 3;
        end
    endfunction

    // Sample both instances in one cycle (called just after a negedge)
    task automatic sample(input int c);
        for (int d = 0; d < 2; d++) begin
            if (resp_valid_w[d]) begin
                if (obs_nresp[d] == 0) begin
                    obs_lat[d]   = c;
                    obs_rdata[d] = resp_rdata_w[d];
                    obs_err[d]   = resp_err_w[d];
                end
                obs_nresp[d]++;
            end
            if (mem_we_w[d]) begin
                obs_wcnt[d]++;
                obs_wcyc[d]  = c;
                obs_wdata[d] = mem_wdata_w[d];
                obs_waddr[d] = mem_addr_w[d];
            end
            if (mem_addr_w[d][1:0] != 2'b00) obs_badal[d] = 1'b1;
        end
    endtask

    task automatic clear_obs();
        for (int d = 0; d < 2; d++) begin
            obs_lat[d] = 0; obs_nresp[d] = 0; obs_rdata[d] = '0; obs_err[d] = 1'b0;
            obs_wcnt[d] = 0; obs_wcyc[d] = 0; obs_wdata[d] = '0; obs_waddr[d] = '0;
            obs_badal[d] = 1'b0;
        end
    endtask

    // One request with a single-cycle valid, observed for a fixed window, checked against the model
    task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
        logic [31:0] e_rd;
        bit          e_err;
        int          e_lat, e_nwe, e_wcyc;
        logic [31:0] e_word;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk($sformatf("d%0d ready", d), 32'(req_ready_w[d]), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        clear_obs();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Scramble the request lines; the latched copy must be used
                req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
            sample(c);
        end
        for (int d = 0; d < 2; d++) begin
            model(d, d == 0, we, f3, addr, wd, e_rd, e_err, e_lat, e_nwe, e_wcyc, e_word);
            chk($sformatf("d%0d resp cycle a=%h f3=%0d we=%0d", d, addr, f3, we), 32'(obs_lat[d]), 32'(e_lat));
            chk($sformatf("d%0d resp count", d), 32'(obs_nresp[d]), 32'd1);
            chk($sformatf("d%0d rdata a=%h f3=%0d", d, addr, f3), obs_rdata[d], e_rd);
            chk($sformatf("d%0d err a=%h f3=%0d we=%0d", d, addr, f3, we), 32'(obs_err[d]), 32'(e_err));
            chk($sformatf("d%0d mem_we pulses", d), 32'(obs_wcnt[d]), 32'(e_nwe));
            chk($sformatf("d%0d mem_addr aligned", d), 32'(obs_badal[d]), 32'd0);
            if (e_nwe != 0) begin
                chk($sformatf("d%0d mem_we cycle", d), 32'(obs_wcyc[d]), 32'(e_wcyc));
                chk($sformatf("d%0d write data", d), obs_wdata[d], e_word);
                chk($sformatf("d%0d write addr", d), obs_waddr[d], {addr[31:2], 2'b00});
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d resp_valid", tag, d), 32'(resp_valid_w[d]), 32'd0);
            chk($sformatf("%s d%0d resp_rdata", tag, d), resp_rdata_w[d], 32'd0);
            chk($sformatf("%s d%0d resp_err", tag, d), 32'(resp_err_w[d]), 32'd0);
            chk($sformatf("%s d%0d mem_we", tag, d), 32'(mem_we_w[d]), 32'd0);
            chk($sformatf("%s d%0d mem_addr", tag, d), mem_addr_w[d], 32'd0);
            chk($sformatf("%s d%0d mem_wdata", tag, d), mem_wdata_w[d], 32'd0);
        end
    endtask

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] r0;
        bit          e0;
        int          l0;
        logic [31:0] r1;
        bit          e1;
        int          l1;
    } vec_t;

    vec_t vt[14];

    initial begin
        int first_resp[2];
        int second_resp[2];
        logic [31:0] e_rd;
        bit          e_err;
        int          e_lat, e_nwe, e_wcyc;
        logic [31:0] e_word;

        vt[0]  = '{1'b0, 3'd2, 32'h80, 32'h0,        32'hdeadbeef, 1'b0, 3, 32'hdeadbeef, 1'b0, 3};
        vt[1]  = '{1'b0, 3'd0, 32'h83, 32'h0,        32'hffffffde, 1'b0, 3, 32'hffffffde, 1'b0, 3};
        vt[2]  = '{1'b0, 3'd4, 32'h83, 32'h0,        32'h000000de, 1'b0, 3, 32'h000000de, 1'b0, 3};
        vt[3]  = '{1'b0, 3'd1, 32'h82, 32'h0,        32'hffffdead, 1'b0, 3, 32'hffffdead, 1'b0, 3};
        vt[4]  = '{1'b0, 3'd5, 32'h80, 32'h0,        32'h0000beef, 1'b0, 3, 32'h0000beef, 1'b0, 3};
        vt[5]  = '{1'b1, 3'd0, 32'h81, 32'h12345678, 32'h0,        1'b0, 4, 32'h0,        1'b0, 4};
        vt[6]  = '{1'b0, 3'd2, 32'h80, 32'h0,        32'hdead78ef, 1'b0, 3, 32'hdead78ef, 1'b0, 3};
        vt[7]  = '{1'b1, 3'd1, 32'h86, 32'h0000cafe, 32'h0,        1'b0, 4, 32'h0,        1'b0, 4};
        vt[8]  = '{1'b0, 3'd2, 32'h84, 32'h0,        32'hcafecced, 1'b0, 3, 32'hcafecced, 1'b0, 3};
        vt[9]  = '{1'b1, 3'd2, 32'h84, 32'h0012ffea, 32'h0,        1'b0, 2, 32'h0,        1'b0, 2};
        vt[10] = '{1'b0, 3'd2, 32'h84, 32'h0,        32'h0012ffea, 1'b0, 3, 32'h0012ffea, 1'b0, 3};
        vt[11] = '{1'b0, 3'd2, 32'h82, 32'h0,        32'h0,        1'b1, 1, 32'hdead78ef, 1'b0, 3};
        vt[12] = '{1'b0, 3'd3, 32'h80, 32'h0,        32'h0,        1'b1, 1, 32'h0,        1'b1, 1};
        vt[13] = '{1'b1, 3'd3, 32'h80, 32'hffffffff, 32'h0,        1'b1, 1, 32'h0,        1'b1, 1};

        for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
        init_mem[32] = 32'hdeadbeef;
        init_mem[33] = 32'haffecced;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 64; i++) refm[d][i] = init_mem[i];

        // Clock/reset
        rst = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        @(negedge clk);
        preload = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk($sformatf("in reset d%0d ready", d), 32'(req_ready_w[d]), 32'd0);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            run_txn(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd);
            chk($sformatf("vec%0d d0 rdata", i), obs_rdata[0], vt[i].r0);
            chk($sformatf("vec%0d d0 err", i), 32'(obs_err[0]), 32'(vt[i].e0));
            chk($sformatf("vec%0d d0 cycle", i), 32'(obs_lat[0]), 32'(vt[i].l0));
            chk($sformatf("vec%0d d1 rdata", i), obs_rdata[1], vt[i].r1);
            chk($sformatf("vec%0d d1 err", i), 32'(obs_err[1]), 32'(vt[i].e1));
            chk($sformatf("vec%0d d1 cycle", i), 32'(obs_lat[1]), 32'(vt[i].l1));
        end

        // Back-to-back: SW with valid held, then LW accepted the cycle after RESP
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h84; req_wdata = 32'h0012ffea;
        clear_obs();
        first_resp[0] = 0; first_resp[1] = 0; second_resp[0] = 0; second_resp[1] = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (resp_valid_w[d]) begin
                    if (first_resp[d] == 0) first_resp[d] = c;
                    else if (second_resp[d] == 0) begin
                        second_resp[d] = c;
                        chk($sformatf("b2b d%0d lw rdata", d), resp_rdata_w[d], 32'h0012ffea);
                    end
                end
                if (mem_we_w[d]) obs_wcnt[d]++;
            end
            if (c == 2) begin
                req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h84; req_wdata = 32'h0;
            end
            if (c == 3) for (int d = 0; d < 2; d++) chk($sformatf("b2b d%0d ready after resp", d), 32'(req_ready_w[d]), 32'd1);
            if (c == 4) req_valid = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            model(d, d == 0, 1'b1, 3'd2, 32'h84, 32'h0012ffea, e_rd, e_err, e_lat, e_nwe, e_wcyc, e_word);
            chk($sformatf("b2b d%0d sw resp cycle", d), 32'(first_resp[d]), 32'(e_lat));
            chk($sformatf("b2b d%0d lw resp cycle", d), 32'(second_resp[d]), 32'd6);
            chk($sformatf("b2b d%0d mem_we pulses", d), 32'(obs_wcnt[d]), 32'd1);
        end

        // Reset during MERGE of SB 0x80: write must be abandoned
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h80; req_wdata = 32'ha5a5a5a5;
        clear_obs();
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            sample(c);
            if (c == 2) rst = 1'b1;
            if (c == 3) begin
                for (int d = 0; d < 2; d++) chk($sformatf("mid rst d%0d ready", d), 32'(req_ready_w[d]), 32'd0);
                chk_reset_outputs("mid rst");
                rst = 1'b0;
            end
            if (c == 4) begin
                for (int d = 0; d < 2; d++) chk($sformatf("post rst d%0d ready", d), 32'(req_ready_w[d]), 32'd1);
                chk_reset_outputs("post rst");
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("mid rst d%0d mem_we pulses", d), 32'(obs_wcnt[d]), 32'd0);
            chk($sformatf("mid rst d%0d resp count", d), 32'(obs_nresp[d]), 32'd0);
            chk($sformatf("mid rst d%0d word32", d), mem[d][32], refm[d][32]);
        end

        // Randomized requests against the model
        for (int n = 0; n < 80; n++) begin
            run_txn(1'($urandom), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom);
        end

        // Final memory contents
        @(negedge clk);
        for (int d = 0; d < 2; d++) for (int i = 0; i < 64; i++)
            chk($sformatf("d%0d mem word %0d", d, i), mem[d][i], refm[d][i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
